// File: rtl/frame_scanner.sv
// frame_scanner: raster-scans a pixel source over ram_addr_x/ram_addr_y and
// shifts each 16-bit RGB565 pixel out MSB first on a write-only SPI link
// (mode 0). One frame per start request.
// Optional build macro FRAME_SCANNER_AUTO_REPEAT_EN: once a frame has been
// started, DONE loops straight back to FETCH so frames repeat until reset.
module frame_scanner #(
  parameter int H_PIXELS = 96,
  parameter int V_PIXELS = 64,
  parameter int SCLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  ram_addr_x,
  output logic [7:0]  ram_addr_y,
  input  logic [15:0] ram_data,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        spi_dc,
  output logic        busy,
  output logic        frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHIFT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam int             DW       = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic [7:0]     X_LAST   = 8'(H_PIXELS - 1);
  localparam logic [7:0]     Y_LAST   = 8'(V_PIXELS - 1);

  state_t        state_q, state_d;
  logic [7:0]    x_q, x_d, y_q, y_d;
  logic [15:0]   shift_q, shift_d;
  logic [3:0]    bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic          phase_q, phase_d;   // 0: SCLK low half, 1: SCLK high half
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          cs_n_q, cs_n_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state and next-output computation for the scan FSM.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    div_d   = div_q;
    phase_d = phase_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        x_d = 8'd0;
        y_d = 8'd0;
        // In auto-repeat builds start only kicks off the first frame.
        if (start) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
          cs_n_d  = 1'b0;
        end
      end
      S_FETCH: begin
        // Addresses changed on the previous edge; the source has settled.
        shift_d = ram_data;
        mosi_d  = ram_data[15];
        bit_d   = 4'd15;
        div_d   = '0;
        phase_d = 1'b0;
        sclk_d  = 1'b0;
        cs_n_d  = 1'b0;
        busy_d  = 1'b1;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DW'(1);
        end else begin
          div_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else begin
            // End of high half: MOSI moves to the next bit together with
            // the falling SCLK, so it never changes while SCLK is high.
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            shift_d = {shift_q[14:0], 1'b0};
            if (bit_q == 4'd0) begin
              state_d = S_NEXT;
            end else begin
              bit_d  = bit_q - 4'd1;
              mosi_d = shift_q[14];
            end
          end
        end
      end
      S_NEXT: begin
        sclk_d = 1'b0;
        if (x_q == X_LAST) begin
          x_d = 8'd0;
          if (y_q == Y_LAST) begin
            state_d = S_DONE;
          end else begin
            y_d     = y_q + 8'd1;
            state_d = S_FETCH;
          end
        end else begin
          x_d     = x_q + 8'd1;
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        cs_n_d = 1'b1;
        done_d = 1'b1;
        x_d    = 8'd0;
        y_d    = 8'd0;
`ifdef FRAME_SCANNER_AUTO_REPEAT_EN
        busy_d  = 1'b1;
        state_d = S_FETCH;
`else
        busy_d  = 1'b0;
        state_d = S_IDLE;
`endif
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cs_n_d  = 1'b1;
      end
    endcase
  end

  // State and registered outputs; synchronous active-low reset aborts at once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      x_q     <= 8'd0;
      y_q     <= 8'd0;
      shift_q <= 16'd0;
      bit_q   <= 4'd0;
      div_q   <= '0;
      phase_q <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ram_addr_x = x_q;
  assign ram_addr_y = y_q;
  assign spi_sclk   = sclk_q;
  assign spi_mosi   = mosi_q;
  assign spi_cs_n   = cs_n_q;
  assign spi_dc     = 1'b1;   // pixel data only; commands come from the init block
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_frame_scanner.sv
// Bench for frame_scanner: random pixel source, SPI receiver model decoding
// the serial stream, expected pixels listed in raster order from the source
// table, plus frame latency, start-while-busy and mid-frame reset checks.
module tb_frame_scanner;

  localparam int H   = 3;
  localparam int V   = 2;
  localparam int DIV = 3;
  localparam int L   = H * V * (32 * DIV + 2) + 1;   // start edge -> frame_done

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  ram_addr_x, ram_addr_y;
  logic [15:0] ram_data;
  logic        spi_sclk, spi_mosi, spi_cs_n, spi_dc, busy, frame_done;

  frame_scanner #(.H_PIXELS(H), .V_PIXELS(V), .SCLK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_addr_x(ram_addr_x), .ram_addr_y(ram_addr_y), .ram_data(ram_data),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_dc(spi_dc), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // pixel source: combinational lookup, out-of-range addresses give a marker
  logic [15:0] pix [V][H];
  always_comb begin
    ram_data = 16'hDEAD;
    if (int'(ram_addr_x) < H && int'(ram_addr_y) < V)
      ram_data = pix[int'(ram_addr_y)][int'(ram_addr_x)];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] exp_q[$];

  // SPI receiver model: samples on SCLK rising edges, checks phase lengths
  int          nbits = 0;
  int          run = 0;
  logic        prv_sclk = 1'b0;
  logic        prv_mosi = 1'b0;
  logic [15:0] rx = 16'd0;
  always @(negedge clk) begin
    if (!rst) begin
      nbits = 0;
      run = 0;
      prv_sclk = 1'b0;
      prv_mosi = spi_mosi;
    end else begin
      if (prv_sclk && spi_sclk) chk("mosi_hold", spi_mosi, prv_mosi);
      if (spi_sclk == prv_sclk) begin
        run++;
      end else begin
        if (prv_sclk) begin
          chk("sclk_high_len", run, DIV);
        end else begin
          if (nbits % 16 != 0) chk("sclk_low_len", run, DIV);
          chk("cs_at_sample", spi_cs_n, 0);
          rx = {rx[14:0], spi_mosi};
          nbits++;
          if (nbits % 16 == 0) begin
            if (exp_q.size() == 0) chk("pixel_extra", exp_q.size(), 1);
            else chk("pixel", rx, exp_q.pop_front());
          end
        end
        run = 1;
      end
      prv_sclk = spi_sclk;
      prv_mosi = spi_mosi;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_sclk"}, spi_sclk, 0);
    chk({tag, "_mosi"}, spi_mosi, 0);
    chk({tag, "_cs_n"}, spi_cs_n, 1);
    chk({tag, "_dc"}, spi_dc, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_x"}, ram_addr_x, 0);
    chk({tag, "_y"}, ram_addr_y, 0);
  endtask

  task automatic load_frame();
    exp_q.delete();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        pix[y][x] = 16'($urandom());
        exp_q.push_back(pix[y][x]);
      end
  endtask

  task automatic kick();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("cs_fall", spi_cs_n, 0);
  endtask

  task automatic run_frame(input bit noisy);
    int cyc;
    bit got;
    load_frame();
    kick();
    cyc = 0;
    got = 0;
    while (!got && cyc < L + 20) begin
      @(posedge clk);
      #1 cyc++;
      if (frame_done) got = 1;
      else if (noisy) start = ($urandom_range(0, 3) == 0);
    end
    start = 1'b0;
    chk("frame_latency", cyc, L);
    chk("busy_end", busy, 0);
    chk("cs_end", spi_cs_n, 1);
    chk("addr_x_end", ram_addr_x, 0);
    chk("addr_y_end", ram_addr_y, 0);
    chk("pixels_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", frame_done, 0);
    chk("no_restart", busy, 0);
    chk("cs_gap", spi_cs_n, 1);
  endtask

  initial begin
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) pix[y][x] = 16'd0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset("reset");
    rst = 1'b1;
    run_frame(1'b0);
    run_frame(1'b1);
    run_frame(1'b1);
    // abort mid-SHIFT of the first pixel, then a clean frame from (0,0)
    load_frame();
    kick();
    repeat (60) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset("abort");
    exp_q.delete();
    rst = 1'b1;
    run_frame(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/frame_scanner.md
# frame_scanner

Pixel-streaming transmitter that reads a framebuffer/animation source through the `ram_addr_x`/`ram_addr_y`/`ram_data` interface and shifts each 16-bit RGB565 pixel out to the OLED panel over a write-only SPI link. It sits between the animation pixel sources (which answer addresses combinationally) and the panel pins. It scans one full frame per request in raster order.

## Interface
Parameters:
- `H_PIXELS`, 96, pixels per row (1..256)
- `V_PIXELS`, 64, rows per frame (1..256)
- `SCLK_DIV`, 4, `clk` cycles per SCLK half-period (≥1)

Ports:
- `clk`  in  1  single system clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-low
- `start`  in  1  frame request; sampled only in IDLE
- `ram_addr_x`  out  8  pixel column address to source
- `ram_addr_y`  out  8  pixel row address to source
- `ram_data`  in  16  RGB565 pixel; combinational function of the addresses, valid the cycle after the addresses change
- `spi_sclk`  out  1  SPI clock, mode 0 (idle low, panel samples on rising edge)
- `spi_mosi`  out  1  serial data, MSB first
- `spi_cs_n`  out  1  chip select, active low
- `spi_dc`  out  1  data/command; fixed 1 (pixel data)
- `busy`  out  1  high from leaving IDLE until return to IDLE
- `frame_done`  out  1  one-cycle pulse at frame completion

## Operation
- All outputs registered. Reset values (`rst`=0 at a rising edge): `ram_addr_x`=0, `ram_addr_y`=0, `spi_sclk`=0, `spi_mosi`=0, `spi_cs_n`=1, `spi_dc`=1, `busy`=0, `frame_done`=0, state IDLE.
- Reset mid-frame aborts immediately; no partial pixel is completed; `spi_cs_n` returns to 1 on the same edge.
- FSM states:
  - IDLE: addresses held at 0. `start`=1 → FETCH; `busy`←1, `spi_cs_n`←0.
  - FETCH (1 cycle): capture `ram_data` into a 16-bit shift register; bit counter ←15 → SHIFT.
  - SHIFT: per bit: `spi_mosi`←shift[15] with `spi_sclk`=0 for `SCLK_DIV` cycles, then `spi_sclk`=1 for `SCLK_DIV` cycles; `spi_mosi` is stable throughout the high phase. After the high phase of bit 0 → NEXT.
  - NEXT (1 cycle): `spi_sclk`←0; if x==H_PIXELS-1 then x←0, y←y+1, else x←x+1; if (x,y) was (H_PIXELS-1, V_PIXELS-1) → DONE, else → FETCH.
  - DONE (1 cycle): `spi_cs_n`←1, `frame_done`←1, addresses←0 → IDLE (see Configuration).
- The address update in NEXT gives the source exactly one cycle (into FETCH) to settle before capture.
- `start` is ignored outside IDLE; no queuing.
- Address counters are sized to 8 bits; x never exceeds H_PIXELS-1, y never exceeds V_PIXELS-1; no wrap past frame end.
- `spi_dc` is constant 1 after reset; command traffic belongs to a separate init block.

## Timing
- `start` sampled at edge N → `busy`=1, `spi_cs_n`=0 after edge N; capture of pixel (0,0) at edge N+1.
- Per pixel: 1 (FETCH) + 32·SCLK_DIV (SHIFT) + 1 (NEXT) cycles; defaults give 130 cycles.
- Frame: H_PIXELS·V_PIXELS·(32·SCLK_DIV+2) cycles from entering FETCH to entering DONE, then 1 DONE cycle.
- `frame_done` high for exactly the cycle after DONE is entered; `busy` falls on the same edge that sets IDLE.
- `spi_cs_n` high for ≥1 cycle between consecutive frames.

## Configuration
- `FRAME_SCANNER_AUTO_REPEAT_EN`:
  - Defined: DONE → FETCH directly (`spi_cs_n` high for exactly the DONE cycle, `busy` stays 1). Frames repeat indefinitely until reset; `start` unused.
  - Undefined: DONE → IDLE; each frame needs a new `start`.

## Test plan
- Reset: hold `rst`=0 for 3 cycles mid-SHIFT → all outputs at reset values, state IDLE, next `start` begins at (0,0).
- Single pixel: H=1, V=1, SCLK_DIV=1, source returns 16'hA5C3 → 16 rising SCLK edges sample 1010_0101_1100_0011; `frame_done` pulses once 35 cycles after `start`.
- Raster order: H=4, V=2, SCLK_DIV=1, source returns {y,x} → pixels captured as 0x0000..0x0003, 0x0100..0x0103; total 272 cycles FETCH→DONE.
- Start while busy: pulse `start` repeatedly during a frame → exactly one `frame_done`, no restart.
- SCLK shape: SCLK_DIV=3 → each SCLK low and high phase 3 cycles; `spi_mosi` never changes while `spi_sclk`=1.
- Auto-repeat (macro defined): H=2, V=1 → `frame_done` pulses every 2·34+1=69 cycles; `spi_cs_n`=1 for exactly 1 cycle between frames.
